// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with a registered read port, occupancy level, threshold flags, and any depth of 2 or more.
// Define SYNC_FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags; otherwise they are tied to 0.
module param_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = 14,
   parameter int AE_THRESH  = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_req,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         rd_req,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   input  logic                         clr_err,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_AF    = LVL_W'(AF_THRESH);
   localparam logic [LVL_W-1:0] LVL_AE    = LVL_W'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0]      level_reg, level_next;
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic                  rd_valid_reg;
   logic                  wr_accept, rd_accept;

   // Flags come only from the registered level, so full blocks writes even when a read frees a slot.
   assign full         = (level_reg == LVL_DEPTH);
   assign empty        = (level_reg == '0);
   assign almost_full  = (level_reg >= LVL_AF);
   assign almost_empty = (level_reg <= LVL_AE);
   assign level        = level_reg;
   assign rd_data      = rd_data_reg;
   assign rd_valid     = rd_valid_reg;

   assign wr_accept = wr_req & ~full;
   assign rd_accept = rd_req & ~empty;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (wr_accept)
         wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (rd_accept)
         rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({wr_accept, rd_accept})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_next;
         rd_valid_reg <= rd_accept;
         if (rd_accept)
            rd_data_reg <= mem[rd_ptr_reg];
      end
   end

   // Storage carries no reset so it maps onto block RAM; reset only discards it via the pointers.
   always_ff @(posedge clk) begin
      if (wr_accept)
         mem[wr_ptr_reg] <= wr_data;
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_reg, underflow_reg;

   // A new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_req && full)
            overflow_reg <= 1'b1;
         else if (clr_err)
            overflow_reg <= 1'b0;
         if (rd_req && empty)
            underflow_reg <= 1'b1;
         else if (clr_err)
            underflow_reg <= 1'b0;
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`else
   logic unused_clr_err;

   assign unused_clr_err = clr_err;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at DEPTH=5, AF_THRESH=4, AE_THRESH=1.
// Expected error-flag values follow whether SYNC_FIFO_ERR_FLAGS_EN is defined for the build.
module tb_param_sync_fifo;

   localparam int DW  = 8;
   localparam int DEP = 5;
   localparam int LW  = $clog2(DEP + 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_req, rd_req, clr_err;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          rd_valid, full, empty, almost_full, almost_empty;
   logic [LW-1:0] level;
   logic          overflow, underflow;

   int checks = 0;
   int errors = 0;

   param_sync_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEP), .AF_THRESH(4), .AE_THRESH(1)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_req(wr_req), .wr_data(wr_data),
      .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
      .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .level(level), .clr_err(clr_err),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ae", 32'(almost_empty), 1);
      chk("rst_af", 32'(almost_full), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_unf", 32'(underflow), 0);
      $display("reset: level=%0d empty=%0b full=%0b", level, empty, full);
      reset = 1'b0;

      // Fill with 0x11..0x55, first write on the first edge after reset release
      for (int i = 1; i <= 5; i++) begin
         wr_req = 1'b1; wr_data = 8'(8'h11 * i);
         tick();
         $display("write 0x%02h: level=%0d ae=%0b af=%0b full=%0b", wr_data, level, almost_empty, almost_full, full);
         chk("fill_level", 32'(level), 32'(i));
         chk("fill_ae", 32'(almost_empty), (i <= 1) ? 1 : 0);
         chk("fill_af", 32'(almost_full), (i >= 4) ? 1 : 0);
         chk("fill_full", 32'(full), (i == 5) ? 1 : 0);
      end
      wr_req = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         rd_req = 1'b1;
         tick();
         $display("read: rd_valid=%0b rd_data=0x%02h level=%0d", rd_valid, rd_data, level);
         chk("drain_valid", 32'(rd_valid), 1);
         chk("drain_data", 32'(rd_data), 32'(8'h11 * i));
         chk("drain_level", 32'(level), 32'(5 - i));
      end
      rd_req = 1'b0;
      tick();
      $display("idle: rd_valid=%0b rd_data=0x%02h empty=%0b", rd_valid, rd_data, empty);
      chk("idle_valid", 32'(rd_valid), 0);
      chk("idle_hold", 32'(rd_data), 32'h55);
      chk("idle_empty", 32'(empty), 1);

      // Empty with write+read: write goes in, read rejected, no bypass
      wr_req = 1'b1; wr_data = 8'hA5; rd_req = 1'b1;
      tick();
      $display("empty wr+rd: level=%0d rd_valid=%0b underflow=%0b", level, rd_valid, underflow);
      chk("empty_level", 32'(level), 1);
      chk("empty_no_valid", 32'(rd_valid), 0);
      chk("empty_hold", 32'(rd_data), 32'h55);
      chk("empty_unf", 32'(underflow), 32'(ERR_EN));
      wr_req = 1'b0;
      tick();
      $display("read after empty: rd_valid=%0b rd_data=0x%02h", rd_valid, rd_data);
      chk("a5_valid", 32'(rd_valid), 1);
      chk("a5_data", 32'(rd_data), 32'hA5);
      chk("a5_level", 32'(level), 0);
      chk("a5_unf_sticky", 32'(underflow), 32'(ERR_EN));
      rd_req = 1'b0; clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      $display("clr_err: underflow=%0b", underflow);
      chk("unf_cleared", 32'(underflow), 0);

      // Level 2, then 10 simultaneous write+read cycles, then drain: 12 words through a 5-deep ring
      for (int i = 0; i < 2; i++) begin
         wr_req = 1'b1; wr_data = 8'(8'h60 + i);
         tick();
      end
      chk("pre_wrap_level", 32'(level), 2);
      for (int i = 0; i < 10; i++) begin
         wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'(8'h62 + i);
         tick();
         $display("wr+rd: wrote 0x%02h read 0x%02h valid=%0b level=%0d", wr_data, rd_data, rd_valid, level);
         chk("wrap_valid", 32'(rd_valid), 1);
         chk("wrap_data", 32'(rd_data), 32'(8'h60 + i));
         chk("wrap_level", 32'(level), 2);
      end
      wr_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_req = 1'b1;
         tick();
         $display("tail read: rd_data=0x%02h level=%0d", rd_data, level);
         chk("tail_data", 32'(rd_data), 32'(8'h6A + i));
         chk("tail_level", 32'(level), 32'(1 - i));
      end
      rd_req = 1'b0;

      // Full with write+read (and clr_err): read accepted, write rejected
      for (int i = 0; i < 5; i++) begin
         wr_req = 1'b1; wr_data = 8'(8'h80 + i);
         tick();
      end
      chk("pre_full", 32'(full), 1);
      wr_req = 1'b1; wr_data = 8'hEE; rd_req = 1'b1; clr_err = 1'b1;
      tick();
      $display("full wr+rd: rd_data=0x%02h level=%0d overflow=%0b", rd_data, level, overflow);
      chk("full_valid", 32'(rd_valid), 1);
      chk("full_data", 32'(rd_data), 32'h80);
      chk("full_level", 32'(level), 4);
      chk("full_ovf", 32'(overflow), 32'(ERR_EN));
      wr_req = 1'b0; clr_err = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         $display("post-full read: rd_data=0x%02h level=%0d", rd_data, level);
         chk("post_full_data", 32'(rd_data), 32'(8'h80 + i));
      end
      rd_req = 1'b0;
      tick();
      chk("post_full_empty", 32'(empty), 1);
      chk("ovf_sticky", 32'(overflow), 32'(ERR_EN));

      // Reset at level 3 with a read in flight
      for (int i = 0; i < 3; i++) begin
         wr_req = 1'b1; wr_data = 8'(8'h31 + i);
         tick();
      end
      wr_req = 1'b0; rd_req = 1'b1;
      tick();
      chk("pre_rst_data", 32'(rd_data), 32'h31);
      chk("pre_rst_level", 32'(level), 2);
      reset = 1'b1;
      tick();
      $display("mid reset: level=%0d empty=%0b rd_valid=%0b rd_data=0x%02h ovf=%0b", level, empty, rd_valid, rd_data, overflow);
      chk("mrst_level", 32'(level), 0);
      chk("mrst_empty", 32'(empty), 1);
      chk("mrst_valid", 32'(rd_valid), 0);
      chk("mrst_data", 32'(rd_data), 0);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_unf", 32'(underflow), 0);
      reset = 1'b0; rd_req = 1'b0;

      wr_req = 1'b1; wr_data = 8'h77;
      tick();
      chk("post_rst_level", 32'(level), 1);
      wr_req = 1'b0; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      $display("post reset read: rd_data=0x%02h rd_valid=%0b", rd_data, rd_valid);
      chk("post_rst_data", 32'(rd_data), 32'h77);
      chk("post_rst_empty", 32'(empty), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
